// File: rtl/r_type_pkg.sv
// Shared encodings, FSM state type and RV32I field helpers for the R-type
// execution controller.
package r_type_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;
  localparam logic [2:0] F3_SUB_ADD = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WB,
    ERR
  } state_t;

  function automatic logic [6:0] opcode_of(input logic [31:0] w);
    return w[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] w);
    return w[11:7];
  endfunction

  function automatic logic [2:0] funct3_of(input logic [31:0] w);
    return w[14:12];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] w);
    return w[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] w);
    return w[24:20];
  endfunction

  function automatic logic [6:0] funct7_of(input logic [31:0] w);
    return w[31:25];
  endfunction

  // Only SUB and SRA may use the alternate funct7 encoding.
  function automatic logic is_legal(input logic [31:0] w);
    logic alt_ok;
    alt_ok = (funct7_of(w) == F7_ALT) &&
             ((funct3_of(w) == F3_SUB_ADD) || (funct3_of(w) == F3_SRL_SRA));
    return (opcode_of(w) == OPC_OP) && ((funct7_of(w) == F7_BASE) || alt_ok);
  endfunction

endpackage

// File: rtl/r_type_exec_ctrl_decode.sv
// Combinational decode: legality of the incoming word and register fields of
// the latched word.
module r_type_decode
  import r_type_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] instr_q,
  output logic        legal,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  assign legal = is_legal(instr);
  assign rs1   = rs1_of(instr_q);
  assign rs2   = rs2_of(instr_q);
  assign rd    = rd_of(instr_q);

endmodule

// File: rtl/r_type_exec_ctrl.sv
// Four-cycle sequencer for one R-type instruction: read operands, drive the
// external ALU, write back rd.
module r_type_exec_ctrl
  import r_type_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  output logic [31:0]        alu_instr,
  output logic [XLEN-1:0]    alu_in1,
  output logic [XLEN-1:0]    alu_in2,
  input  logic [XLEN-1:0]    alu_out,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               done,
  output logic               illegal,
  output logic               busy,
  output logic [CNT_W-1:0]   retired_cnt
);

  state_t            state, next;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   result_q;
  logic              legal;
  logic [4:0]        rs1, rs2, rd;
  logic              accept;

  r_type_decode u_decode (
    .instr   (instr),
    .instr_q (instr_q),
    .legal   (legal),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd)
  );

  assign instr_ready = (state == IDLE) && !flush && !rst;
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_q     <= '0;
      result_q    <= '0;
      retired_cnt <= '0;
    end else begin
      state <= next;
      if (accept)
        instr_q <= instr;
      if (state == EXEC && !flush)
        result_q <= alu_out;
      if (done)
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next      = state;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    alu_instr = '0;
    alu_in1   = '0;
    alu_in2   = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: if (accept) next = legal ? READ : ERR;
      READ: begin
        rf_raddr1 = RADDR_W'(rs1);
        rf_raddr2 = RADDR_W'(rs2);
        next      = EXEC;
      end
      EXEC: begin
        alu_instr = instr_q;
        alu_in1   = rf_rdata1;
        alu_in2   = rf_rdata2;
        next      = WB;
      end
      WB: begin
        rf_waddr = RADDR_W'(rd);
        rf_wdata = result_q;
        rf_we    = (rd != '0);
        done     = 1'b1;
        next     = IDLE;
      end
      ERR: begin
        illegal = 1'b1;
        next    = IDLE;
      end
      default: next = IDLE;
    endcase
    // A flush kills the side effects of whatever stage it lands on.
    if (flush && state != IDLE) begin
      next    = IDLE;
      rf_we   = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_r_type_exec_ctrl.sv
// Bench for r_type_exec_ctrl with a behavioural ALU, a sync-read register file
// and a transaction-level reference model.
module tb_r_type_exec_ctrl;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst, flush, instr_valid, instr_ready;
  logic [31:0]     instr;
  logic [RW-1:0]   rf_raddr1, rf_raddr2, rf_waddr;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2, alu_in1, alu_in2, alu_out, rf_wdata;
  logic [31:0]     alu_instr;
  logic            rf_we, done, illegal, busy;
  logic [CW-1:0]   retired_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  r_type_exec_ctrl #(.XLEN(XLEN), .RADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_instr(alu_instr), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .illegal(illegal), .busy(busy), .retired_cnt(retired_cnt)
  );

  // RV32I R-type arithmetic, also used as the external ALU.
  function automatic logic [31:0] alu_fn(input logic [31:0] w, input logic [31:0] a,
                                         input logic [31:0] b);
    logic alt;
    alt = w[30];
    case (w[14:12])
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit legal_ref(input logic [31:0] w);
    if (w[6:0] != 7'h33) return 0;
    if (w[31:25] == 7'h00) return 1;
    if (w[31:25] == 7'h20 && (w[14:12] == 3'd0 || w[14:12] == 3'd5)) return 1;
    return 0;
  endfunction

  assign alu_out = alu_fn(alu_instr, alu_in1, alu_in2);

  // Register file environment: stores every write (x0 included) so stray writes show up.
  logic [31:0] mem [32];
  logic        pl_we;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    rf_rdata1 <= mem[rf_raddr1];
    rf_rdata2 <= mem[rf_raddr2];
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (rf_we) mem[rf_waddr] <= rf_wdata;
  end

  logic [31:0] ref_x [32];
  int          ref_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
    ref_x[a] = d;
  endtask

  task automatic run(input logic [31:0] w);
    logic [31:0] a, b, res;
    bit          lg;
    lg  = legal_ref(w);
    a   = ref_x[w[19:15]];
    b   = ref_x[w[24:20]];
    res = alu_fn(w, a, b);
    instr = w; instr_valid = 1'b1;
    #1 check("ready_n", instr_ready, 1);
    tick();
    instr_valid = 1'b0; instr = $urandom;
    check("ready_n1", instr_ready, 0);
    if (lg) begin
      check("busy_read", busy, 1);
      check("raddr1", rf_raddr1, w[19:15]);
      check("raddr2", rf_raddr2, w[24:20]);
      check("illegal_read", illegal, 0);
      tick();
      check("alu_in1", alu_in1, a);
      check("alu_in2", alu_in2, b);
      check("alu_instr", alu_instr, w);
      check("we_exec", rf_we, 0);
      instr_valid = 1'b1;
      tick();
      check("ready_wb", instr_ready, 0);
      check("we_wb", rf_we, w[11:7] != 5'd0);
      check("waddr", rf_waddr, w[11:7]);
      check("wdata", rf_wdata, res);
      check("done_wb", done, 1);
      instr_valid = 1'b0;
      if (w[11:7] != 5'd0) ref_x[w[11:7]] = res;
      ref_cnt++;
      tick();
      check("done_after", done, 0);
      check("wdata_after", rf_wdata, 0);
      check("ready_n4", instr_ready, 1);
      check("cnt", retired_cnt, ref_cnt % 16);
      check("rf_dst", mem[w[11:7]], ref_x[w[11:7]]);
    end else begin
      check("illegal_n1", illegal, 1);
      check("we_err", rf_we, 0);
      check("done_err", done, 0);
      tick();
      check("illegal_n2", illegal, 0);
      check("ready_n2", instr_ready, 1);
      check("cnt_err", retired_cnt, ref_cnt % 16);
    end
  endtask

  // Flush while the instruction sits in READ (1), EXEC (2) or WB (3).
  task automatic flush_at(input logic [31:0] w, input int stage);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    repeat (stage - 1) tick();
    flush = 1'b1;
    #1;
    check("flush_we", rf_we, 0);
    check("flush_done", done, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy", busy, 0);
    check("flush_ready", instr_ready, 1);
    check("flush_we2", rf_we, 0);
    check("flush_cnt", retired_cnt, ref_cnt % 16);
    check("flush_rf", mem[w[11:7]], ref_x[w[11:7]]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7, op;
    r = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h33;
    return {f7, r[24:7], op};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    ref_cnt = 0;
    preload(5'd0, 32'd0);
    for (int i = 1; i < 32; i++) preload(5'(i), $urandom);
    check("rst_busy", busy, 0);
    check("rst_cnt", retired_cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_raddr1", rf_raddr1, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_wdata", rf_wdata, 0);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    run(32'h002081B3);
    check("add_x3", ref_x[3], 32'd8);
    preload(5'd2, 32'd7);
    run(32'h40208233);
    check("sub_x4", ref_x[4], 32'hFFFF_FFFE);
    run(32'h00208033);
    check("x0_zero", mem[0], 0);
    run(32'h00000013);
    run(32'h40209233);
    run(32'h4020D233);

    preload(5'd5, 32'hDEAD);
    flush_at(32'h002082B3, 1);
    flush_at(32'h002082B3, 2);
    flush_at(32'h002082B3, 3);

    flush = 1'b1; instr_valid = 1'b1; instr = 32'h002081B3;
    #1 check("flush_idle_ready", instr_ready, 0);
    tick();
    flush = 1'b0; instr_valid = 1'b0;
    #1 check("flush_idle_busy", busy, 0);

    instr = 32'h002082B3; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    ref_cnt = 0;
    check("rstmid_busy", busy, 0);
    check("rstmid_raddr1", rf_raddr1, 0);
    check("rstmid_raddr2", rf_raddr2, 0);
    check("rstmid_cnt", retired_cnt, 0);
    check("rstmid_ready", instr_ready, 1);
    repeat (3) begin
      tick();
      check("rstmid_done", done, 0);
    end
    check("rstmid_rf", mem[5], ref_x[5]);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) preload(5'($urandom_range(1, 31)), $urandom);
      run(rand_instr());
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_cnt = 0;
    for (int i = 0; i < 16; i++)
      run({7'h00, 5'($urandom), 5'($urandom), 3'd0, 5'($urandom_range(1, 31)), 7'h33});
    check("wrap_cnt", retired_cnt, 0);
    check("x0_final", mem[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
